// File: rtl/spi_4slaves.sv
// spi_4slaves: loopback SPI subsystem with one master and four slaves wired
// internally. Each accepted tx_start runs one full-duplex DATA_W-bit exchange
// (mode 0, MSB first) with the currently selected slave. The target then
// advances round-robin 1->2->3->4->1.
module spi_4slaves #(
  parameter int DATA_W  = 10,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] master_data_in,
  input  logic [DATA_W-1:0] slave_data_in1,
  input  logic [DATA_W-1:0] slave_data_in2,
  input  logic [DATA_W-1:0] slave_data_in3,
  input  logic [DATA_W-1:0] slave_data_in4,
  output logic [DATA_W-1:0] master_data_out,
  output logic [DATA_W-1:0] slave_data_out1,
  output logic [DATA_W-1:0] slave_data_out2,
  output logic [DATA_W-1:0] slave_data_out3,
  output logic [DATA_W-1:0] slave_data_out4,
  output logic              master_tx_done,
  output logic              master_rx_done,
  output logic              slave_tx_done1,
  output logic              slave_tx_done2,
  output logic              slave_tx_done3,
  output logic              slave_tx_done4,
  output logic              slave_rx_done1,
  output logic              slave_rx_done2,
  output logic              slave_rx_done3,
  output logic              slave_rx_done4
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [1:0]        sel;
  logic              sclk;
  logic [3:0]        ss_n;
  logic              mosi;
  logic              miso;

  // Master transmits from m_tx and assembles the received word in m_rx.
  logic [DATA_W-1:0] m_tx;
  logic [DATA_W-1:0] m_rx;

  // Per-slave transmit/receive shift registers and last-received words.
  logic [DATA_W-1:0] s_in  [4];
  logic [DATA_W-1:0] s_tx  [4];
  logic [DATA_W-1:0] s_rx  [4];
  logic [DATA_W-1:0] s_out [4];
  logic [3:0]        s_tx_done;
  logic [3:0]        s_rx_done;

  // Gather the slave input ports into an indexable array.
  always_comb begin
    s_in[0] = slave_data_in1;
    s_in[1] = slave_data_in2;
    s_in[2] = slave_data_in3;
    s_in[3] = slave_data_in4;
  end

  // Serial wires: MOSI from master MSB, MISO muxed from the selected slave.
  always_comb begin
    mosi = m_tx[DATA_W-1];
    miso = 1'b0;
    if (!ss_n[sel]) begin
      miso = s_tx[sel][DATA_W-1];
    end
  end

  // Master FSM, SCLK generation and the slaves' shift logic.
  // Receive bits go into separate rx registers so the transmit word is not
  // disturbed before its low bits have been shifted out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_cnt         <= '0;
      sel             <= '0;
      sclk            <= 1'b0;
      ss_n            <= '1;
      m_tx            <= '0;
      m_rx            <= '0;
      master_data_out <= '0;
      master_tx_done  <= 1'b0;
      master_rx_done  <= 1'b0;
      s_tx_done       <= '0;
      s_rx_done       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        s_tx[i]  <= '0;
        s_rx[i]  <= '0;
        s_out[i] <= '0;
      end
    end else begin
      master_tx_done <= 1'b0;
      master_rx_done <= 1'b0;
      s_tx_done      <= '0;
      s_rx_done      <= '0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            m_tx       <= master_data_in;
            m_rx       <= '0;
            s_tx[sel]  <= s_in[sel];
            s_rx[sel]  <= '0;
            ss_n[sel]  <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            state      <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt  <= '0;
            sclk <= ~sclk;
            if (!sclk) begin
              m_rx <= {m_rx[DATA_W-2:0], miso};
              for (int unsigned i = 0; i < 4; i++) begin
                if (!ss_n[i]) s_rx[i] <= {s_rx[i][DATA_W-2:0], mosi};
              end
            end else begin
              m_tx <= m_tx << 1;
              for (int unsigned i = 0; i < 4; i++) begin
                if (!ss_n[i]) s_tx[i] <= s_tx[i] << 1;
              end
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_W'(DATA_W - 1)) state <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          master_data_out <= m_rx;
          s_out[sel]      <= s_rx[sel];
          master_tx_done  <= 1'b1;
          master_rx_done  <= 1'b1;
          s_tx_done[sel]  <= 1'b1;
          s_rx_done[sel]  <= 1'b1;
          ss_n            <= '1;
          sel             <= sel + 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign slave_data_out1 = s_out[0];
  assign slave_data_out2 = s_out[1];
  assign slave_data_out3 = s_out[2];
  assign slave_data_out4 = s_out[3];
  assign slave_tx_done1  = s_tx_done[0];
  assign slave_tx_done2  = s_tx_done[1];
  assign slave_tx_done3  = s_tx_done[2];
  assign slave_tx_done4  = s_tx_done[3];
  assign slave_rx_done1  = s_rx_done[0];
  assign slave_rx_done2  = s_rx_done[1];
  assign slave_rx_done3  = s_rx_done[2];
  assign slave_rx_done4  = s_rx_done[3];

endmodule

// File: tb/tb_spi_4slaves.sv
// Testbench for spi_4slaves: randomized and directed exchanges checked
// against a word-level model (swap of master word and selected slave word,
// round-robin target, fixed done latency).
module tb_spi_4slaves;

  localparam int LAT = 20 * 4 + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [9:0] m_in = '0;
  logic [9:0] s_in [4];
  logic [9:0] master_data_out;
  logic [9:0] slave_data_out1, slave_data_out2, slave_data_out3, slave_data_out4;
  logic       master_tx_done, master_rx_done;
  logic       slave_tx_done1, slave_tx_done2, slave_tx_done3, slave_tx_done4;
  logic       slave_rx_done1, slave_rx_done2, slave_rx_done3, slave_rx_done4;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int unsigned msel = 0;
  logic [9:0]  exp_m = '0;
  logic [9:0]  exp_s [4];
  logic [9:0]  exp_pv = '0;

  logic [9:0]  pulses;
  logic [39:0] s_outs;
  logic [39:0] exp_outs;

  assign pulses = {master_tx_done, master_rx_done,
                   slave_tx_done4, slave_tx_done3, slave_tx_done2, slave_tx_done1,
                   slave_rx_done4, slave_rx_done3, slave_rx_done2, slave_rx_done1};
  assign s_outs   = {slave_data_out4, slave_data_out3, slave_data_out2, slave_data_out1};
  assign exp_outs = {exp_s[3], exp_s[2], exp_s[1], exp_s[0]};

  always #5 clk = ~clk;

  spi_4slaves #(.DATA_W(10), .CLK_DIV(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tx_start        (tx_start),
    .master_data_in  (m_in),
    .slave_data_in1  (s_in[0]),
    .slave_data_in2  (s_in[1]),
    .slave_data_in3  (s_in[2]),
    .slave_data_in4  (s_in[3]),
    .master_data_out (master_data_out),
    .slave_data_out1 (slave_data_out1),
    .slave_data_out2 (slave_data_out2),
    .slave_data_out3 (slave_data_out3),
    .slave_data_out4 (slave_data_out4),
    .master_tx_done  (master_tx_done),
    .master_rx_done  (master_rx_done),
    .slave_tx_done1  (slave_tx_done1),
    .slave_tx_done2  (slave_tx_done2),
    .slave_tx_done3  (slave_tx_done3),
    .slave_tx_done4  (slave_tx_done4),
    .slave_rx_done1  (slave_rx_done1),
    .slave_rx_done2  (slave_rx_done2),
    .slave_rx_done3  (slave_rx_done3),
    .slave_rx_done4  (slave_rx_done4)
  );

  task automatic randomize_inputs();
    m_in = 10'($urandom);
    for (int i = 0; i < 4; i++) s_in[i] = 10'($urandom);
  endtask

  task automatic model_reset();
    msel  = 0;
    exp_m = '0;
    for (int i = 0; i < 4; i++) exp_s[i] = '0;
  endtask

  // Starts one exchange, updates the model, and waits (bounded) for the first
  // done pulse. lat is the edge count from the start edge, or 0 when no done
  // pulse arrives within the bound.
  task automatic xfer(input bit noisy, input bit scramble, input bit hold,
                      output int lat, output logic [9:0] pv);
    logic [3:0] oh;
    tx_start = 1'b1;
    @(posedge clk); #1;
    oh = 4'(1 << msel);
    exp_m       = s_in[msel];
    exp_s[msel] = m_in;
    exp_pv      = {2'b11, oh, oh};
    msel        = (msel + 1) % 4;
    if (!hold) tx_start = 1'b0;
    if (scramble) randomize_inputs();
    lat = 0;
    pv  = '0;
    for (int k = 1; k <= 200; k++) begin
      if (noisy) tx_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (pulses !== 10'b0) begin
        lat = k;
        pv  = pulses;
        break;
      end
    end
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic test_reset();
    int stray;
    reset_n  = 1'b0;
    tx_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tests++;
    if ({master_data_out, s_outs} !== 50'b0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h expected 0", master_data_out, s_outs);
    end
    tests++;
    if (pulses !== 10'b0) begin
      fails++;
      $display("FAIL reset_done: got %b expected 0", pulses);
    end
    reset_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pulses !== 10'b0 || master_data_out !== 10'b0) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL reset_idle: got %0d active cycles expected 0", stray);
    end
  endtask

  task automatic test_directed();
    logic [9:0] svals [5];
    int lat;
    logic [9:0] pv;
    svals[0] = 10'h0DA; svals[1] = 10'h2D9; svals[2] = 10'h2B7;
    svals[3] = 10'h06E; svals[4] = 10'h155;
    m_in = 10'h2AC;
    for (int n = 0; n < 5; n++) begin
      s_in[n % 4] = svals[n];
      xfer(1'b0, 1'b0, 1'b0, lat, pv);
      tests++;
      if (lat != LAT) begin
        fails++;
        $display("FAIL dir_latency[%0d]: got %0d expected %0d", n, lat, LAT);
      end
      tests++;
      if (pv !== exp_pv) begin
        fails++;
        $display("FAIL dir_pulses[%0d]: got %b expected %b", n, pv, exp_pv);
      end
      tests++;
      if (master_data_out !== svals[n]) begin
        fails++;
        $display("FAIL dir_master_out[%0d]: got %h expected %h", n, master_data_out, svals[n]);
      end
      tests++;
      if (s_outs !== exp_outs) begin
        fails++;
        $display("FAIL dir_slave_outs[%0d]: got %h expected %h", n, s_outs, exp_outs);
      end
      @(posedge clk); #1;
      tests++;
      if (pulses !== 10'b0) begin
        fails++;
        $display("FAIL dir_pulse_width[%0d]: got %b expected 0", n, pulses);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [9:0] pv;
    for (int n = 0; n < 8; n++) begin
      randomize_inputs();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      xfer(1'b0, 1'b1, 1'b0, lat, pv);
      tests++;
      if (lat != LAT || pv !== exp_pv) begin
        fails++;
        $display("FAIL rnd_done[%0d]: got lat %0d pv %b expected lat %0d pv %b",
                 n, lat, pv, LAT, exp_pv);
      end
      tests++;
      if (master_data_out !== exp_m || s_outs !== exp_outs) begin
        fails++;
        $display("FAIL rnd_data[%0d]: got %h/%h expected %h/%h",
                 n, master_data_out, s_outs, exp_m, exp_outs);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int stray;
    logic [9:0] pv;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      xfer(1'b1, 1'b0, 1'b0, lat, pv);
      stray = 0;
      repeat (LAT + 10) begin
        @(posedge clk); #1;
        if (pulses !== 10'b0) stray++;
      end
      tests++;
      if (lat != LAT || pv !== exp_pv) begin
        fails++;
        $display("FAIL ign_done[%0d]: got lat %0d pv %b expected lat %0d pv %b",
                 n, lat, pv, LAT, exp_pv);
      end
      tests++;
      if (stray != 0) begin
        fails++;
        $display("FAIL ign_queued[%0d]: got %0d extra pulse cycles expected 0", n, stray);
      end
      tests++;
      if (master_data_out !== exp_m || s_outs !== exp_outs) begin
        fails++;
        $display("FAIL ign_data[%0d]: got %h/%h expected %h/%h",
                 n, master_data_out, s_outs, exp_m, exp_outs);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [9:0] pv;
    randomize_inputs();
    xfer(1'b0, 1'b0, 1'b1, lat, pv);
    tests++;
    if (lat != LAT || pv !== exp_pv || master_data_out !== exp_m || s_outs !== exp_outs) begin
      fails++;
      $display("FAIL b2b_first: got lat %0d pv %b data %h/%h expected lat %0d pv %b data %h/%h",
               lat, pv, master_data_out, s_outs, LAT, exp_pv, exp_m, exp_outs);
    end
    randomize_inputs();
    xfer(1'b0, 1'b0, 1'b0, lat, pv);
    tests++;
    if (lat != LAT || pv !== exp_pv || master_data_out !== exp_m || s_outs !== exp_outs) begin
      fails++;
      $display("FAIL b2b_second: got lat %0d pv %b data %h/%h expected lat %0d pv %b data %h/%h",
               lat, pv, master_data_out, s_outs, LAT, exp_pv, exp_m, exp_outs);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    logic [9:0] pv;
    // Make sure the aborted transfer would not target slave1, so the
    // post-reset target really shows the selector was cleared.
    while (msel == 0) begin
      randomize_inputs();
      xfer(1'b0, 1'b0, 1'b0, lat, pv);
    end
    randomize_inputs();
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    stray = 0;
    repeat (LAT / 2) begin
      @(posedge clk); #1;
      if (pulses !== 10'b0) stray++;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    tests++;
    if ({master_data_out, s_outs} !== 50'b0 || pulses !== 10'b0) begin
      fails++;
      $display("FAIL rstmid_clear: got %h/%h pulses %b expected all 0",
               master_data_out, s_outs, pulses);
    end
    reset_n = 1'b1;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (pulses !== 10'b0) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL rstmid_nodone: got %0d pulse cycles expected 0", stray);
    end
    randomize_inputs();
    xfer(1'b0, 1'b0, 1'b0, lat, pv);
    tests++;
    if (lat != LAT || pv !== 10'b11_0001_0001) begin
      fails++;
      $display("FAIL rstmid_target: got lat %0d pv %b expected lat %0d pv %b",
               lat, pv, LAT, 10'b11_0001_0001);
    end
    tests++;
    if (master_data_out !== exp_m || s_outs !== exp_outs) begin
      fails++;
      $display("FAIL rstmid_data: got %h/%h expected %h/%h",
               master_data_out, s_outs, exp_m, exp_outs);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) s_in[i] = '0;
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
